// File: rtl/ddc_config_sequencer_pkg.sv
// Shared types for the DDC configuration sequencer: state encoding, phase width default
// and the channel-index width helper.
package ddc_seq_pkg;

   localparam int PHASE_W_DEF = 20;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      GAP    = 3'd2,
      RESYNC = 3'd3,
      FIN    = 3'd4
   } seq_state_t;

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddc_config_sequencer_if.sv
// Command/table-write side and per-channel strobe side of the sequencer, bundled as one port.
// master = register bridge / driver, slave = sequencer.
interface ddc_config_sequencer_if #(
   parameter int N_CH    = 4,
   parameter int PHASE_W = ddc_seq_pkg::PHASE_W_DEF,
   parameter int GAP_W   = 8
);
   localparam int CH_W = ddc_seq_pkg::ch_idx_w(N_CH);

   logic               tbl_wr_en;
   logic [CH_W-1:0]    tbl_wr_ch;
   logic [PHASE_W-1:0] tbl_wr_pinc;
   logic [PHASE_W-1:0] tbl_wr_poff;
   logic               start;
   logic               abort;
   logic [N_CH-1:0]    ch_mask;
   logic [GAP_W-1:0]   gap;
   logic [N_CH-1:0]    p_valid;
   logic [PHASE_W-1:0] cfg_pinc;
   logic [PHASE_W-1:0] cfg_poff;
   logic               resync_out;
   logic               busy;
   logic               done;
   logic               wr_err;

   modport master (
      output tbl_wr_en, tbl_wr_ch, tbl_wr_pinc, tbl_wr_poff, start, abort, ch_mask, gap,
      input  p_valid, cfg_pinc, cfg_poff, resync_out, busy, done, wr_err
   );

   modport slave (
      input  tbl_wr_en, tbl_wr_ch, tbl_wr_pinc, tbl_wr_poff, start, abort, ch_mask, gap,
      output p_valid, cfg_pinc, cfg_poff, resync_out, busy, done, wr_err
   );

endinterface

// File: rtl/ddc_config_sequencer_table.sv
// Shadow pinc/poff register file: one synchronous write port, one combinational read port,
// cleared asynchronously by dev_rst.
module ddc_seq_table
   import ddc_seq_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int CH_W    = ch_idx_w(N_CH)
) (
   input  logic               dev_clk,
   input  logic               dev_rst,
   input  logic               wr_en,
   input  logic [CH_W-1:0]    wr_ch,
   input  logic [PHASE_W-1:0] wr_pinc,
   input  logic [PHASE_W-1:0] wr_poff,
   input  logic [CH_W-1:0]    rd_ch,
   output logic [PHASE_W-1:0] rd_pinc,
   output logic [PHASE_W-1:0] rd_poff
);

   logic [2*PHASE_W-1:0] mem [N_CH];

   always_ff @(posedge dev_clk or posedge dev_rst) begin
      if (dev_rst) begin
         for (int i = 0; i < N_CH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_ch] <= {wr_pinc, wr_poff};
      end
   end

   assign {rd_pinc, rd_poff} = mem[rd_ch];

endmodule

// File: rtl/ddc_config_sequencer.sv
// Replays the shadow pinc/poff table into the DDC bank as one-hot single-cycle strobes.
// Define DDC_SEQ_AUTO_RESYNC_EN to add a RESYNC state that pulses resync_out after the scan.
module ddc_config_sequencer
   import ddc_seq_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int GAP_W   = 8
) (
   input  logic                   dev_clk,
   input  logic                   dev_rst,
   ddc_config_sequencer_if.slave  bus
);

   localparam int CH_W = ch_idx_w(N_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
`ifdef DDC_SEQ_AUTO_RESYNC_EN
   localparam seq_state_t END_ST = RESYNC;
`else
   localparam seq_state_t END_ST = FIN;
`endif

   seq_state_t         state, nxt_state;
   logic [CH_W-1:0]    idx, nxt_idx;
   logic [GAP_W-1:0]   gcnt, nxt_gcnt, gcnt_dec, gap_q;
   logic [N_CH-1:0]    mask_q, mask_use;
   logic               go, wr_ok, byp;
   logic [PHASE_W-1:0] tbl_pinc, tbl_poff, fwd_pinc, fwd_poff;

   logic [N_CH-1:0]    pv_q, pv_nxt;
   logic [PHASE_W-1:0] pinc_q, pinc_nxt, poff_q, poff_nxt;
   logic               busy_q, busy_nxt, done_q, done_nxt, wr_err_q, wr_err_nxt;

   assign go       = (state == IDLE) && bus.start;
   assign wr_ok    = (state == IDLE) && bus.tbl_wr_en;
   assign gcnt_dec = (gcnt != '0) ? gcnt - GAP_W'(1) : '0;

   ddc_seq_table #(.N_CH(N_CH), .PHASE_W(PHASE_W), .CH_W(CH_W)) u_table (
      .dev_clk (dev_clk),
      .dev_rst (dev_rst),
      .wr_en   (wr_ok),
      .wr_ch   (bus.tbl_wr_ch),
      .wr_pinc (bus.tbl_wr_pinc),
      .wr_poff (bus.tbl_wr_poff),
      .rd_ch   (nxt_idx),
      .rd_pinc (tbl_pinc),
      .rd_poff (tbl_poff)
   );

   // A write landing on the start edge must be seen by the first strobe.
   assign byp      = wr_ok && (bus.tbl_wr_ch == nxt_idx);
   assign fwd_pinc = byp ? bus.tbl_wr_pinc : tbl_pinc;
   assign fwd_poff = byp ? bus.tbl_wr_poff : tbl_poff;

   always_ff @(posedge dev_clk or posedge dev_rst) begin
      if (dev_rst) begin
         state    <= IDLE;
         idx      <= '0;
         gcnt     <= '0;
         mask_q   <= '0;
         gap_q    <= '0;
         pv_q     <= '0;
         pinc_q   <= '0;
         poff_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state    <= nxt_state;
         idx      <= nxt_idx;
         gcnt     <= nxt_gcnt;
         if (go) begin
            mask_q <= bus.ch_mask;
            gap_q  <= bus.gap;
         end
         pv_q     <= pv_nxt;
         pinc_q   <= pinc_nxt;
         poff_q   <= poff_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         wr_err_q <= wr_err_nxt;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_gcnt  = gcnt;
      case (state)
         IDLE: begin
            if (bus.start) begin
               nxt_state = SCAN;
               nxt_idx   = '0;
            end
         end
         SCAN: begin
            if (bus.abort) begin
               nxt_state = IDLE;
            end else if (mask_q[idx] && (gap_q != '0)) begin
               nxt_state = GAP;
               nxt_gcnt  = gap_q;
            end else if (idx == LAST_CH) begin
               nxt_state = END_ST;
            end else begin
               nxt_idx = idx + CH_W'(1);
            end
         end
         GAP: begin
            nxt_gcnt = gcnt_dec;
            if (bus.abort) begin
               nxt_state = IDLE;
            end else if (gcnt_dec == '0) begin
               if (idx == LAST_CH) begin
                  nxt_state = END_ST;
               end else begin
                  nxt_state = SCAN;
                  nxt_idx   = idx + CH_W'(1);
               end
            end
         end
`ifdef DDC_SEQ_AUTO_RESYNC_EN
         RESYNC: nxt_state = bus.abort ? IDLE : FIN;
`endif
         FIN:     nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // Outputs are registered from the next-state view so each strobe shares its cycle with the visit.
   always_comb begin
      mask_use = (state == IDLE) ? bus.ch_mask : mask_q;
      pv_nxt   = '0;
      if ((nxt_state == SCAN) && mask_use[nxt_idx]) begin
         pv_nxt = N_CH'(1) << nxt_idx;
      end
      pinc_nxt   = (pv_nxt != '0) ? fwd_pinc : pinc_q;
      poff_nxt   = (pv_nxt != '0) ? fwd_poff : poff_q;
      busy_nxt   = (nxt_state == SCAN) || (nxt_state == GAP) || (nxt_state == RESYNC);
      done_nxt   = (nxt_state == FIN);
      wr_err_nxt = wr_err_q;
      if (go) begin
         wr_err_nxt = 1'b0;
      end else if (bus.tbl_wr_en && (state != IDLE)) begin
         wr_err_nxt = 1'b1;
      end
   end

`ifdef DDC_SEQ_AUTO_RESYNC_EN
   logic resync_q;

   always_ff @(posedge dev_clk or posedge dev_rst) begin
      if (dev_rst) begin
         resync_q <= 1'b0;
      end else begin
         resync_q <= (nxt_state == RESYNC) && (mask_q != '0);
      end
   end

   assign bus.resync_out = resync_q;
`else
   assign bus.resync_out = 1'b0;
`endif

   assign bus.p_valid  = pv_q;
   assign bus.cfg_pinc = pinc_q;
   assign bus.cfg_poff = poff_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_ddc_config_sequencer.sv
// Scoreboard bench for ddc_config_sequencer: expected strobe/resync/done events are queued at
// start time and matched, with their cycle, against every active output cycle.
module tb_ddc_config_sequencer;

   localparam int N_CH    = 4;
   localparam int PHASE_W = 20;
   localparam int GAP_W   = 8;
   localparam int NOCUT   = 1000000;

   typedef struct {
      int          cyc;
      logic [63:0] v;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   ev_t  q[$];
   ev_t  mev;
   logic [19:0] tbl_p [4];
   logic [19:0] tbl_o [4];
   logic [19:0] last_p = '0;
   logic [19:0] last_o = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ddc_config_sequencer_if #(.N_CH(N_CH), .PHASE_W(PHASE_W), .GAP_W(GAP_W)) bus ();

   ddc_config_sequencer #(.N_CH(N_CH), .PHASE_W(PHASE_W), .GAP_W(GAP_W)) dut (
      .dev_clk (clk),
      .dev_rst (rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pack_ev(input logic [3:0] pv, input logic [19:0] p,
                                           input logic [19:0] o, input logic rs,
                                           input logic dn, input logic bs);
      return {17'd0, pv, p, o, rs, dn, bs};
   endfunction

   // Expected events of one replay starting in cycle e; events at or after cut never happen.
   task automatic model(input logic [3:0] m, input logic [7:0] g, input int e, input int cut);
      int t;
      ev_t ev;
      logic [3:0] one;
      t   = e;
      one = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            if (t < cut) begin
               last_p = tbl_p[k];
               last_o = tbl_o[k];
               ev.cyc = t;
               ev.v   = pack_ev(one << k, last_p, last_o, 1'b0, 1'b0, 1'b1);
               q.push_back(ev);
            end
            t += 1 + int'(g);
         end else begin
            t += 1;
         end
      end
`ifdef DDC_SEQ_AUTO_RESYNC_EN
      if ((m != 4'd0) && (t < cut)) begin
         ev.cyc = t;
         ev.v   = pack_ev(4'd0, last_p, last_o, 1'b1, 1'b0, 1'b1);
         q.push_back(ev);
      end
      t += 1;
`endif
      if (t < cut) begin
         ev.cyc = t;
         ev.v   = pack_ev(4'd0, last_p, last_o, 1'b0, 1'b1, 1'b0);
         q.push_back(ev);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ((bus.p_valid != '0) || bus.resync_out || bus.done)) begin
         chk("onehot", 64'($countones(bus.p_valid) <= 1), 64'd1);
         if (q.size() == 0) begin
            chk("unexpected_evt", pack_ev(bus.p_valid, bus.cfg_pinc, bus.cfg_poff,
                                          bus.resync_out, bus.done, bus.busy), 64'd0);
         end else begin
            mev = q.pop_front();
            chk("evt_cyc", 64'(cyc), 64'(mev.cyc));
            chk("evt_dat", pack_ev(bus.p_valid, bus.cfg_pinc, bus.cfg_poff,
                                   bus.resync_out, bus.done, bus.busy), mev.v);
         end
      end
   end

   task automatic tbl_write(input logic [1:0] ch, input logic [19:0] p, input logic [19:0] o);
      @(negedge clk);
      bus.tbl_wr_en   = 1'b1;
      bus.tbl_wr_ch   = ch;
      bus.tbl_wr_pinc = p;
      bus.tbl_wr_poff = o;
      tbl_p[ch] = p;
      tbl_o[ch] = o;
      @(negedge clk);
      bus.tbl_wr_en = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] m, input logic [7:0] g, input int cut_rel,
                           input logic ab, input logic w_en, input logic [1:0] w_ch,
                           input logic [19:0] w_p, input logic [19:0] w_o);
      int e;
      @(negedge clk);
      bus.start       = 1'b1;
      bus.ch_mask     = m;
      bus.gap         = g;
      bus.abort       = ab;
      bus.tbl_wr_en   = w_en;
      bus.tbl_wr_ch   = w_ch;
      bus.tbl_wr_pinc = w_p;
      bus.tbl_wr_poff = w_o;
      if (w_en) begin
         tbl_p[w_ch] = w_p;
         tbl_o[w_ch] = w_o;
      end
      e = cyc + 1;
      model(m, g, e, (cut_rel >= NOCUT) ? NOCUT : e + cut_rel);
      @(negedge clk);
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.tbl_wr_en = 1'b0;
   endtask

   initial begin
      bus.tbl_wr_en   = 1'b0;
      bus.tbl_wr_ch   = '0;
      bus.tbl_wr_pinc = '0;
      bus.tbl_wr_poff = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.ch_mask     = '0;
      bus.gap         = '0;
      for (int k = 0; k < 4; k++) begin
         tbl_p[k] = '0;
         tbl_o[k] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_p_valid", 64'(bus.p_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_resync", 64'(bus.resync_out), 64'd0);
      chk("rst_cfg_pinc", 64'(bus.cfg_pinc), 64'd0);
      chk("rst_wr_err", 64'(bus.wr_err), 64'd0);
      rst = 1'b0;

      // Full mask, no gap
      for (int k = 0; k < 4; k++) begin
         tbl_write(2'(k), 20'h00100 + 20'(k), 20'h00200 + 20'(k));
      end
      do_start(4'hF, 8'd0, NOCUT, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      chk("t1_busy", 64'(bus.busy), 64'd1);
      repeat (12) @(negedge clk);
      chk("t1_drain", 64'(q.size()), 64'd0);

      // Sparse mask with gap; abort alongside start must lose
      do_start(4'b1010, 8'd3, NOCUT, 1'b1, 1'b0, 2'd0, 20'd0, 20'd0);
      chk("t2_busy", 64'(bus.busy), 64'd1);
      repeat (20) @(negedge clk);
      chk("t2_drain", 64'(q.size()), 64'd0);

      // Dropped write while busy, then start with a same-cycle write
      do_start(4'hF, 8'd0, NOCUT, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      bus.tbl_wr_en   = 1'b1;
      bus.tbl_wr_ch   = 2'd2;
      bus.tbl_wr_pinc = 20'h12345;
      bus.tbl_wr_poff = 20'h54321;
      @(negedge clk);
      bus.tbl_wr_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("t3_wr_err_set", 64'(bus.wr_err), 64'd1);
      chk("t3_drain_a", 64'(q.size()), 64'd0);
      do_start(4'hF, 8'd1, NOCUT, 1'b0, 1'b1, 2'd0, 20'h0ABCD, 20'h0DCBA);
      chk("t3_wr_err_clr", 64'(bus.wr_err), 64'd0);
      repeat (16) @(negedge clk);
      chk("t3_drain_b", 64'(q.size()), 64'd0);

      // Abort two cycles after start
      do_start(4'hF, 8'd0, 2, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("t4_busy", 64'(bus.busy), 64'd0);
      chk("t4_p_valid", 64'(bus.p_valid), 64'd0);
      repeat (8) @(negedge clk);
      chk("t4_drain_a", 64'(q.size()), 64'd0);
      do_start(4'hF, 8'd0, NOCUT, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      repeat (10) @(negedge clk);
      chk("t4_drain_b", 64'(q.size()), 64'd0);

      // Asynchronous reset mid-replay
      do_start(4'hF, 8'd0, 1, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_p_valid", 64'(bus.p_valid), 64'd0);
      chk("t5_busy", 64'(bus.busy), 64'd0);
      chk("t5_cfg_pinc", 64'(bus.cfg_pinc), 64'd0);
      chk("t5_cfg_poff", 64'(bus.cfg_poff), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tbl_p[k] = '0;
         tbl_o[k] = '0;
      end
      last_p = '0;
      last_o = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_drain_a", 64'(q.size()), 64'd0);
      do_start(4'hF, 8'd0, NOCUT, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      repeat (10) @(negedge clk);
      chk("t5_drain_b", 64'(q.size()), 64'd0);

      // Empty mask, plus a start while busy that must be ignored
      do_start(4'h0, 8'd0, NOCUT, 1'b0, 1'b0, 2'd0, 20'd0, 20'd0);
      bus.start   = 1'b1;
      bus.ch_mask = 4'hF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(negedge clk);
      chk("t6_drain", 64'(q.size()), 64'd0);
      chk("t6_idle", 64'(bus.busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
